// File: rtl/rd_word_unpacker.sv
// Reads 32-bit words from the 7-bit-addressed Memory and streams them out as
// little-endian bytes over a valid/ready handshake, with a one-word prefetch.
module rd_word_unpacker #(
   parameter int ADR_W  = 7,
   parameter int DATA_W = 32,
   parameter int BYTE_W = 8
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              start,
   input  logic [ADR_W-1:0]  baseAdr,
   input  logic [ADR_W-1:0]  wordCnt,
   input  logic [1:0]        lastBytes,
   output logic [ADR_W-1:0]  memAdr,
   output logic              memRe,
   input  logic [DATA_W-1:0] memData,
   output logic [BYTE_W-1:0] byteOut,
   output logic              byteValid,
   input  logic              byteReady,
   output logic              byteLast,
   output logic              busy,
   output logic              done
);

   localparam int LANES  = DATA_W / BYTE_W;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      CAPT,
      EMIT,
      DONE
   } state_t;

   state_t              state_reg;
   state_t              state_next;

   logic [ADR_W-1:0]    addr_reg;
   logic [ADR_W-1:0]    word_cnt_reg;
   logic [1:0]          last_bytes_reg;
   logic [ADR_W-1:0]    words_issued_reg;
   logic [ADR_W-1:0]    words_loaded_reg;
   logic [LANE_W-1:0]   lane_reg;
   logic [DATA_W-1:0]   shift_reg;
   logic [DATA_W-1:0]   pf_data_reg;
   logic                pf_valid_reg;
   logic                pf_pend_reg;

   logic                mem_re;
   logic                pf_issue;
   logic                byte_valid;
   logic                done_pulse;
   logic                is_final;
   logic                more_issue;
   logic                at_last_lane;
   logic                handshake;
   logic                word_end;
   logic [LANE_W-1:0]   last_lane;

   // The final word may be short; every other word emits all lanes.
   always_comb begin
      last_lane = LANE_W'(LANES - 1);
      if (is_final && last_bytes_reg != 2'd0) begin
         last_lane = LANE_W'(last_bytes_reg - 2'd1);
      end
   end

   assign is_final     = (words_loaded_reg == word_cnt_reg);
   assign more_issue   = (words_issued_reg < word_cnt_reg);
   assign at_last_lane = (lane_reg == last_lane);
   assign handshake    = (state_reg == EMIT) && byteReady;
   assign word_end     = handshake && at_last_lane;

   always_comb begin
      state_next = state_reg;
      mem_re     = 1'b0;
      pf_issue   = 1'b0;
      byte_valid = 1'b0;
      done_pulse = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = (wordCnt != '0) ? REQ : DONE;
            end
         end
         REQ: begin
            mem_re     = 1'b1;
            state_next = CAPT;
         end
         CAPT: begin
            state_next = EMIT;
         end
         EMIT: begin
            byte_valid = 1'b1;
            // Fetch the next word while the current one drains; skip on the
            // cycle a word ends so the REQ path never double-issues.
            if (!pf_valid_reg && !pf_pend_reg && more_issue && !word_end) begin
               pf_issue = 1'b1;
               mem_re   = 1'b1;
            end
            if (word_end) begin
               if (pf_valid_reg || pf_pend_reg) begin
                  state_next = EMIT;
               end else if (more_issue) begin
                  state_next = REQ;
               end else begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            done_pulse = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         state_reg        <= IDLE;
         addr_reg         <= '0;
         word_cnt_reg     <= '0;
         last_bytes_reg   <= '0;
         words_issued_reg <= '0;
         words_loaded_reg <= '0;
         lane_reg         <= '0;
         shift_reg        <= '0;
         pf_data_reg      <= '0;
         pf_valid_reg     <= 1'b0;
         pf_pend_reg      <= 1'b0;
      end else begin
         state_reg   <= state_next;
         pf_pend_reg <= pf_issue;

         if (mem_re) begin
            addr_reg         <= addr_reg + ADR_W'(1);
            words_issued_reg <= words_issued_reg + ADR_W'(1);
         end

         if (state_reg == IDLE && start) begin
            addr_reg         <= baseAdr;
            word_cnt_reg     <= wordCnt;
            last_bytes_reg   <= lastBytes;
            words_issued_reg <= '0;
            words_loaded_reg <= '0;
            lane_reg         <= '0;
            pf_valid_reg     <= 1'b0;
         end

         if (state_reg == CAPT) begin
            shift_reg        <= memData;
            lane_reg         <= '0;
            words_loaded_reg <= words_loaded_reg + ADR_W'(1);
         end

         // A returning prefetch is parked unless it is consumed directly below.
         if (pf_pend_reg && !word_end) begin
            pf_data_reg  <= memData;
            pf_valid_reg <= 1'b1;
         end

         if (handshake) begin
            if (at_last_lane) begin
               lane_reg <= '0;
               if (pf_valid_reg) begin
                  shift_reg        <= pf_data_reg;
                  pf_valid_reg     <= 1'b0;
                  words_loaded_reg <= words_loaded_reg + ADR_W'(1);
               end else if (pf_pend_reg) begin
                  shift_reg        <= memData;
                  words_loaded_reg <= words_loaded_reg + ADR_W'(1);
               end
            end else begin
               shift_reg <= shift_reg >> BYTE_W;
               lane_reg  <= lane_reg + LANE_W'(1);
            end
         end
      end
   end

   assign memAdr    = addr_reg;
   assign memRe     = mem_re;
   assign byteValid = byte_valid;
   assign byteOut   = byte_valid ? shift_reg[BYTE_W-1:0] : '0;
   assign byteLast  = byte_valid && is_final && at_last_lane;
   assign busy      = (state_reg != IDLE);
   assign done      = done_pulse;

endmodule

// File: tb/tb_rd_word_unpacker.sv
// Scoreboard bench for rd_word_unpacker: a word-level memory model builds the
// expected byte/address streams, a monitor compares whatever the DUT presents.
module tb_rd_word_unpacker;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        start = 1'b0;
   logic [6:0]  baseAdr = '0;
   logic [6:0]  wordCnt = '0;
   logic [1:0]  lastBytes = '0;
   logic [6:0]  memAdr;
   logic        memRe;
   logic [31:0] memData = '0;
   logic [7:0]  byteOut;
   logic        byteValid;
   logic        byteReady = 1'b0;
   logic        byteLast;
   logic        busy;
   logic        done;

   rd_word_unpacker dut (
      .clk(clk), .rstN(rstN), .start(start), .baseAdr(baseAdr),
      .wordCnt(wordCnt), .lastBytes(lastBytes), .memAdr(memAdr),
      .memRe(memRe), .memData(memData), .byteOut(byteOut),
      .byteValid(byteValid), .byteReady(byteReady), .byteLast(byteLast),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:127];
   always @(posedge clk) if (memRe) memData <= mem[memAdr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;
   logic [8:0] exp_q [$];
   logic [6:0] adr_q [$];
   int exp_done = 0;
   int done_cnt = 0;
   int start_cyc = 0;
   int exp_done_cyc = -1;
   bit first_pend = 1'b0;
   int rdy_mode = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_memAdr"}, 32'(memAdr), 0);
      check({tag, "_memRe"}, 32'(memRe), 0);
      check({tag, "_byteOut"}, 32'(byteOut), 0);
      check({tag, "_byteValid"}, 32'(byteValid), 0);
      check({tag, "_byteLast"}, 32'(byteLast), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
   endtask

   // Reference: a transfer is the byte sequence of consecutive words, low byte first.
   task automatic expect_xfer(input int base, input int cnt, input int lb, output int nb);
      logic [31:0] word;
      int n;
      nb = 0;
      for (int w = 0; w < cnt; w++) begin
         word = mem[(base + w) % 128];
         adr_q.push_back(7'((base + w) % 128));
         n = (w == cnt - 1 && lb != 0) ? lb : 4;
         for (int b = 0; b < n; b++) begin
            exp_q.push_back({(w == cnt - 1 && b == n - 1), word[8*b +: 8]});
            nb++;
         end
      end
   endtask

   task automatic do_start(input int base, input int cnt, input int lb, input int mode, input int nb);
      @(posedge clk); #1;
      baseAdr = 7'(base); wordCnt = 7'(cnt); lastBytes = 2'(lb); start = 1'b1;
      start_cyc = cyc;
      first_pend = (cnt != 0);
      exp_done_cyc = (cnt == 0) ? cyc + 1 : ((mode == 0) ? cyc + 3 + nb : -1);
      exp_done++;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run(input int base, input int cnt, input int lb, input int mode, input int poke);
      int nb, d0, waited;
      rdy_mode = mode;
      expect_xfer(base, cnt, lb, nb);
      d0 = done_cnt;
      do_start(base, cnt, lb, mode, nb);
      if (poke > 0) begin
         repeat (poke) @(posedge clk);
         #1;
         baseAdr = 7'($urandom); wordCnt = 7'($urandom_range(1, 127)); start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      waited = 0;
      while (done_cnt == d0 && waited < 2000) begin
         @(posedge clk);
         waited++;
      end
      check("done_seen", 32'(done_cnt - d0), 1);
      repeat (2) @(posedge clk);
   endtask

   initial begin
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       byteReady = 1'b1;
            1:       byteReady = 1'($urandom_range(0, 1));
            default: byteReady = !byteReady;
         endcase
      end
   end

   // Monitor: compares every presented byte and read address against the queues.
   initial begin
      logic [6:0] a;
      forever begin
         @(negedge clk);
         if (rstN) begin
            if (memRe) begin
               check("memRe_expected", 32'(adr_q.size() != 0), 1);
               if (adr_q.size() != 0) begin
                  a = adr_q.pop_front();
                  check("memAdr", 32'(memAdr), 32'(a));
               end
            end
            if (byteValid) begin
               check("byte_expected", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  check("byte_last_data", 32'({byteLast, byteOut}), 32'(exp_q[0]));
                  if (byteReady) void'(exp_q.pop_front());
               end
               if (first_pend) begin
                  first_pend = 1'b0;
                  check("first_latency", 32'(cyc), 32'(start_cyc + 3));
               end
            end
            if (byteValid || memRe || done) check("busy_active", 32'(busy), 1);
            if (done) begin
               check("done_expected", 32'(exp_done != 0), 1);
               if (exp_done != 0) begin
                  exp_done--;
                  check("bytes_left", 32'(exp_q.size()), 0);
                  check("reads_left", 32'(adr_q.size()), 0);
                  if (exp_done_cyc >= 0) check("done_latency", 32'(cyc), 32'(exp_done_cyc));
               end
               done_cnt++;
            end
         end
      end
   end

   initial begin
      int nb, k;
      for (int i = 0; i < 128; i++) mem[i] = $urandom;

      // Reset and idle
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      rstN = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("idle_busy", 32'(busy), 0);

      // Single word, full throughput
      mem[5] = 32'hDDCCBBAA;
      run(5, 1, 0, 0, 0);
      // Streaming across the address wrap
      run(126, 3, 0, 0, 0);
      // Partial last word with toggling backpressure
      run(40, 2, 2, 2, 0);
      // Zero length
      run(60, 0, 0, 0, 0);
      // Second start during a 4-word transfer is ignored
      run(10, 4, 0, 0, 5);

      // Reset during word 2 of 4
      rdy_mode = 0;
      expect_xfer(80, 4, 0, nb);
      do_start(80, 4, 0, 0, nb);
      k = 0;
      while (exp_q.size() > 11 && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("reached_word2", 32'(exp_q.size() <= 11), 1);
      @(posedge clk); #1;
      rstN = 1'b0;
      @(posedge clk); #1;
      exp_q.delete();
      adr_q.delete();
      exp_done = 0;
      first_pend = 1'b0;
      check_zero("midreset");
      rstN = 1'b1;
      repeat (5) @(posedge clk);
      run(20, 2, 1, 1, 0);

      // Randomized transfers
      for (int t = 0; t < 25; t++) begin
         int c;
         c = $urandom_range(0, 10);
         run($urandom_range(0, 127), c, $urandom_range(0, 3), $urandom_range(0, 2),
             (c >= 2 && $urandom_range(0, 3) == 0) ? 4 : 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/rd_word_unpacker.md
Name: rd_word_unpacker

Overview:
- Read-side counterpart of the WR data register: that register packs 8-bit Calc results into 32-bit memory words; this block fetches 32-bit words from the 7-bit-addressed Memory and streams them out as 8-bit bytes.
- Output is a valid/ready byte stream for filter/view buffer loading and result readback.
- Owns its own address counter, Memory read strobe, one-word prefetch register and control FSM.

Parameters:
- ADR_W, 7, Memory address width.
- DATA_W, 32, Memory word width.
- BYTE_W, 8, output byte width.
- LANES, DATA_W/BYTE_W (4), bytes per word; derived, not overridden.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rstN  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  in  1  one-cycle request; sampled only in IDLE.
- baseAdr  in  ADR_W  first word address; latched on start.
- wordCnt  in  ADR_W  number of words to read, 0..127; latched on start.
- lastBytes  in  2  valid bytes in the final word; 0 means 4. Latched on start.
- memAdr  out  ADR_W  Memory read address.
- memRe  out  1  Memory read enable.
- memData  in  DATA_W  Memory read data, valid one cycle after memRe.
- byteOut  out  BYTE_W  current byte.
- byteValid  out  1  byteOut is valid.
- byteReady  in  1  consumer accepts the byte when byteValid && byteReady at a rising edge.
- byteLast  out  1  high with the final byte of the transfer.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (rstN=0 at an edge): state=IDLE. All outputs 0: memAdr, memRe, byteOut, byteValid, byteLast, busy, done. Counters, shift register and prefetch register cleared. Reset mid-transfer aborts it with no done pulse.
- Byte order: little-endian. Lane 0 = memData[7:0] is emitted first, lane 3 = memData[31:24] last.
- Memory timing: memRe=1 with memAdr=A in cycle t; memData is captured at the edge ending cycle t+1.
- The address increments after each issued read and wraps modulo 2^ADR_W (127 -> 0).
- FSM states: IDLE, REQ, CAPT, EMIT, DONE.
  - IDLE: on start with wordCnt!=0: latch inputs, go to REQ. On start with wordCnt=0: go to DONE; no memRe is issued. start in any other state is ignored.
  - REQ: memRe=1, memAdr=current address; wordsIssued++. Go to CAPT.
  - CAPT: load memData into the shift register, lane=0. Go to EMIT.
  - EMIT:
    - byteValid=1 and byteOut=shift[7:0].
    - On handshake: shift right by 8, lane++.
    - At the last lane of a word (lane=3, or lane=lastBytes-1 on the final word when lastBytes!=0):
      - prefetch valid: load shift register from prefetch, clear prefetch, lane=0, stay in EMIT with no bubble.
      - words remain un-issued: go to REQ.
      - final word: go to DONE.
  - Prefetch in EMIT: if the prefetch register is empty, no prefetch read is in flight, and wordsIssued<wordCnt, assert memRe for one cycle and capture into the prefetch register the next cycle. This sustains 1 byte/cycle when byteReady is held high.
  - DONE: done=1 for one cycle, busy=1. Go to IDLE.
- byteLast=1 only on the final byte of the final word.
- Backpressure: while byteValid && !byteReady, byteOut, byteLast and lane hold stable. A prefetch may still complete during the stall.
- memRe never issues more than wordCnt reads per transfer.
- Latency:
  - start to first byteValid is 3 cycles (IDLE, REQ, CAPT).
  - With byteReady=1 throughout, a transfer of N full words takes 3 + 4N cycles from start to the done pulse, exclusive.

Test Plan:
- Reset then idle: rstN=0 for 2 cycles, then 1 -> all outputs 0, busy=0; no memRe over 10 idle cycles.
- Single word: mem[5]=0xDDCCBBAA, start with baseAdr=5, wordCnt=1, lastBytes=0, byteReady=1 -> memRe at cycle 1 with memAdr=5. Bytes AA, BB, CC, DD in consecutive cycles; byteLast on DD; done one cycle later.
- Streaming with wrap: baseAdr=126, wordCnt=3, byteReady=1 -> reads at 126, 127, 0. Exactly 12 contiguous byteValid cycles with no bubble; exactly 3 memRe pulses.
- Partial last word plus backpressure: wordCnt=2, lastBytes=2, byteReady toggling 1,0,1,0 -> 6 bytes total. Output held stable during stalls; byteLast on the 6th byte.
- Zero length and ignored start: wordCnt=0 -> done pulse 1 cycle after start, no memRe, no byteValid. A second start during a 4-word transfer is ignored; the byte count stays 16.
- Reset mid-transfer: rstN=0 during EMIT of word 2 of 4 -> next cycle all outputs 0, state IDLE, no done. A new start then behaves normally.
